// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } fetch_state_e;

    // Values loaded into the instruction holding register on reset
    localparam logic [XLEN-1:0] RstInst = '0;
    localparam logic [XLEN-1:0] RstPc   = '0;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: PC register, instruction memory and decode-side signals.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic            start_i;
    logic [XLEN-1:0] pc_i;
    logic            stall_o;
    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            id_stall_i;
    logic            flush_i;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            inst_valid_o;
    logic            timeout_o;

    // Controller side
    modport master (
        input  start_i, pc_i, mem_ack_i, mem_rdata_i, id_stall_i, flush_i,
        output stall_o, mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, timeout_o
    );

    // Environment side (PC register, memory, decode)
    modport slave (
        output start_i, pc_i, mem_ack_i, mem_rdata_i, id_stall_i, flush_i,
        input  stall_o, mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, timeout_o
    );

endinterface

// File: rtl/fetch_timer.sv
// Fetch-wait watchdog: counts consecutive un-acked FETCH cycles and raises a
// sticky flag once TIMEOUT_CYC is reached. Only built with FETCH_TIMEOUT_EN.
module fetch_timer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYC);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    // Count while waiting (saturating at the limit); flag is cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (waiting) begin
            if (cnt_q != Limit) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q + 1'b1 == Limit) begin
                timeout_q <= 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests the word at pc_i, stalls the PC
// until the memory acks, and registers the instruction for decode.
// Optional feature macro: FETCH_TIMEOUT_EN (adds the fetch-wait watchdog).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_ctrl_if.master bus
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            inst_valid_q;
    // Set when a flush hits an outstanding request; its ack must be thrown away
    logic            drop_q;

    assign bus.mem_addr_o   = bus.pc_i;
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = inst_pc_q;
    assign bus.inst_valid_o = inst_valid_q;

    // Request and PC stall; the request is dropped in the same cycle start_i falls
    always_comb begin
        bus.mem_req_o = 1'b0;
        bus.stall_o   = 1'b0;
        case (state_q)
            StFetch: begin
                bus.mem_req_o = bus.start_i;
                bus.stall_o   = ~bus.mem_ack_i;
            end
            StHold: begin
                bus.stall_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Control FSM and instruction register; priority start low > flush > ack > id_stall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            inst_q       <= RstInst;
            inst_pc_q    <= RstPc;
            inst_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else if (!bus.start_i) begin
            state_q      <= StIdle;
            inst_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                end
                StFetch: begin
                    if (bus.flush_i) begin
                        // An ack in this cycle is the stale one; otherwise drop the next
                        inst_valid_q <= 1'b0;
                        drop_q       <= ~bus.mem_ack_i;
                    end else if (bus.mem_ack_i && drop_q) begin
                        drop_q <= 1'b0;
                        if (!bus.id_stall_i) begin
                            inst_valid_q <= 1'b0;
                        end
                    end else if (bus.mem_ack_i) begin
                        inst_q       <= bus.mem_rdata_i;
                        inst_pc_q    <= bus.pc_i;
                        inst_valid_q <= 1'b1;
                        state_q      <= bus.id_stall_i ? StHold : StFetch;
                    end else if (!bus.id_stall_i) begin
                        inst_valid_q <= 1'b0;
                    end
                end
                StHold: begin
                    // Decode takes the held word this cycle (or it is flushed)
                    if (bus.flush_i || !bus.id_stall_i) begin
                        inst_valid_q <= 1'b0;
                        state_q      <= StFetch;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic waiting;
    assign waiting = (state_q == StFetch) && !bus.mem_ack_i;

    fetch_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .waiting(waiting),
        .timeout(bus.timeout_o)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign bus.timeout_o      = 1'b0;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, SHALL set the fetch-wait cycle limit used only when FETCH_TIMEOUT_EN is defined.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 start_i  in  1  run enable; low SHALL hold the block idle.
REQ-005 pc_i  in  32  fetch address from the PC register, stable while stall_o is high.
REQ-006 stall_o  out  1  SHALL freeze the PC register when high.
REQ-007 mem_req_o  out  1  instruction-memory request.
REQ-008 mem_addr_o  out  32  SHALL equal pc_i combinationally.
REQ-009 mem_ack_i  in  1  memory ack; mem_rdata_i is valid in the same cycle.
REQ-010 mem_rdata_i  in  32  instruction word.
REQ-011 id_stall_i  in  1  decode stage cannot accept an instruction.
REQ-012 flush_i  in  1  discard the held or pending instruction.
REQ-013 inst_o  out  32  registered instruction to decode.
REQ-014 inst_pc_o  out  32  registered address of inst_o.
REQ-015 inst_valid_o  out  1  inst_o/inst_pc_o are valid.
REQ-016 timeout_o  out  1  sticky fetch-timeout flag.

Function
REQ-017 States SHALL be IDLE, FETCH, HOLD.
REQ-018 IDLE: mem_req_o=0, stall_o=0; start_i=1 -> FETCH next cycle.
REQ-019 FETCH: mem_req_o=1; stall_o=~mem_ack_i, so the PC advances on the ack edge (zero-wait memory gives 1 instr/cycle).
REQ-020 FETCH with mem_ack_i=1, no flush, no drop pending: inst_o<=mem_rdata_i, inst_pc_o<=pc_i, inst_valid_o<=1; next state HOLD if id_stall_i=1, else FETCH.
REQ-021 FETCH with mem_ack_i=0: inst_valid_o<=0 if id_stall_i=0, else hold.
REQ-022 HOLD: mem_req_o=0, stall_o=1, outputs held; id_stall_i=0 -> FETCH, inst_valid_o stays 1 for that cycle (consumed), cleared next cycle unless a new ack.
REQ-023 flush_i=1: inst_valid_o<=0 next cycle; HOLD -> FETCH; ack in the same cycle SHALL be discarded.
REQ-024 flush_i in FETCH with no ack SHALL set a drop flag; the next ack's data SHALL be discarded, the flag cleared, and FETCH continued.
REQ-025 start_i=0 in any state SHALL go to IDLE next cycle, clear inst_valid_o and the drop flag, and drop mem_req_o in the same cycle (the memory tolerates abort).
REQ-026 Priority SHALL be start_i low > flush_i > mem_ack_i > id_stall_i.

Reset
REQ-027 rst_i=1 SHALL immediately force IDLE, inst_o=0, inst_pc_o=0, inst_valid_o=0, drop flag=0, timeout_o=0, timeout counter=0.
REQ-028 Reset mid-FETCH SHALL abort the request with no ack tracking.

Configuration
REQ-029 With FETCH_TIMEOUT_EN defined, a counter SHALL count consecutive FETCH cycles without ack, clear on ack or leaving FETCH, and set timeout_o sticky when it reaches TIMEOUT_CYC; only reset clears it.
REQ-030 Without FETCH_TIMEOUT_EN, no counter SHALL exist and timeout_o SHALL be tied 0.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, XLEN=32 and the reset constants.
REQ-032 The timeout counter SHALL be sub-module fetch_timer, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-033 Zero-wait memory, start_i=1, pc 0,4,8: ack every cycle -> inst_pc_o 0,4,8 on consecutive cycles, stall_o=0.
REQ-034 Ack 3 cycles late at pc=0x10: stall_o=1 for 3 cycles, then inst_o=rdata, inst_pc_o=0x10, inst_valid_o=1.
REQ-035 id_stall_i=1 at ack of 0x20 for 2 cycles: HOLD, outputs frozen, mem_req_o=0, then resume FETCH.
REQ-036 flush_i while waiting at 0x30: following ack discarded, inst_valid_o=0, next ack accepted.
REQ-037 FETCH_TIMEOUT_EN with TIMEOUT_CYC=4, no ack: timeout_o=1 after 4 cycles and stays 1 through start_i toggles until rst_i.
REQ-038 rst_i pulse mid-HOLD: all outputs 0 immediately; IDLE until start_i.
